// File: rtl/max_scan_ctrl.sv
// Streaming 64-lane frame maximum with a 3-stage reduction pipeline and result handshake.
// Define MAX_SCAN_POS_EN to add out_lane/out_beat reporting where the maximum was found.
module max_scan_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [64*DATA_WIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_max,
  output logic [CNT_W-1:0]         out_count,
  output logic                     busy
`ifdef MAX_SCAN_POS_EN
  ,
  output logic [5:0]               out_lane,
  output logic [CNT_W-1:0]         out_beat
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t state, state_nxt;
  logic   drain_cnt;
  logic   accept;

  logic signed [DATA_WIDTH-1:0] lane_val;
  logic signed [DATA_WIDTH-1:0] grp_max [8];
  logic signed [DATA_WIDTH-1:0] s1_max  [8];
  logic                         s1_v;
  logic signed [DATA_WIDTH-1:0] top_max;
  logic signed [DATA_WIDTH-1:0] s2_max;
  logic                         s2_v;
  logic signed [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]             count;

`ifdef MAX_SCAN_POS_EN
  logic [5:0]       grp_lane [8];
  logic [5:0]       s1_lane  [8];
  logic [CNT_W-1:0] s1_beat;
  logic [5:0]       top_lane;
  logic [5:0]       s2_lane;
  logic [CNT_W-1:0] s2_beat;
  logic [5:0]       acc_lane;
  logic [CNT_W-1:0] acc_beat;
  logic [CNT_W-1:0] beat_idx;
`endif

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_max   = acc;
  assign out_count = count;

  // Every reduction starts from zero and only a strictly larger score wins, which gives the
  // clamp-at-zero rule and lowest-lane tie breaking in one comparison.
  always_comb begin
    lane_val = '0;
    for (int g = 0; g < 8; g++) begin
      grp_max[g] = '0;
`ifdef MAX_SCAN_POS_EN
      grp_lane[g] = '0;
`endif
      for (int l = 0; l < 8; l++) begin
        lane_val = $signed(in_data[DATA_WIDTH*(g*8+l) +: DATA_WIDTH]);
        if (lane_val > grp_max[g]) begin
          grp_max[g] = lane_val;
`ifdef MAX_SCAN_POS_EN
          grp_lane[g] = 6'(g*8 + l);
`endif
        end
      end
    end
  end

  always_comb begin
    top_max = '0;
`ifdef MAX_SCAN_POS_EN
    top_lane = '0;
`endif
    for (int g = 0; g < 8; g++) begin
      if (s1_max[g] > top_max) begin
        top_max = s1_max[g];
`ifdef MAX_SCAN_POS_EN
        top_lane = s1_lane[g];
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !drain_cnt && !clr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int g = 0; g < 8; g++) s1_max[g] <= '0;
      s1_v   <= 1'b0;
      s2_max <= '0;
      s2_v   <= 1'b0;
      acc    <= '0;
      count  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) s1_max <= grp_max;
      s2_v <= s1_v;
      if (s1_v) s2_max <= top_max;
      // The pipeline is empty in IDLE, so restarting the accumulator cannot lose a merge.
      if (accept && state == IDLE) acc <= '0;
      else if (s2_v && s2_max > acc) acc <= s2_max;
      if (accept) begin
        if (state == IDLE) count <= CNT_W'(1);
        else if (!(&count)) count <= count + CNT_W'(1);
      end
    end
  end

`ifdef MAX_SCAN_POS_EN
  assign beat_idx = (state == IDLE) ? '0 : count;
  assign out_lane = acc_lane;
  assign out_beat = acc_beat;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int g = 0; g < 8; g++) s1_lane[g] <= '0;
      s1_beat  <= '0;
      s2_lane  <= '0;
      s2_beat  <= '0;
      acc_lane <= '0;
      acc_beat <= '0;
    end else begin
      if (accept) begin
        s1_lane <= grp_lane;
        s1_beat <= beat_idx;
      end
      if (s1_v) begin
        s2_lane <= top_lane;
        s2_beat <= s1_beat;
      end
      if (accept && state == IDLE) begin
        acc_lane <= '0;
        acc_beat <= '0;
      end else if (s2_v && s2_max > acc) begin
        acc_lane <= s2_lane;
        acc_beat <= s2_beat;
      end
    end
  end
`endif

endmodule
